keyb_scan_debounce: RTL and testbench

KEYB_SCAN_DEBOUNCE -- requirements
Module: keyb_scan_debounce

---
 rtl/keyb_scan_debounce.sv | 134 +++++++++++++
 tb/tb_keyb_scan_debounce.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/keyb_scan_debounce.sv
// 4x4 keypad scanner: walks an active-low row strobe, then debounces the first
// low column found into a key code and a held-key qualifier.
module keyb_scan_debounce #(
    parameter int unsigned CLK_DIV        = 4,
    parameter int unsigned DEBOUNCE_TICKS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       enable_filter
);

    localparam int unsigned TW = $clog2(CLK_DIV);
    localparam int unsigned DW = (DEBOUNCE_TICKS < 2) ? 1 : $clog2(DEBOUNCE_TICKS);

    typedef enum logic [1:0] {
        SCAN,
        DEB_PRESS,
        PRESSED,
        DEB_REL
    } state_t;

    state_t          state;
    logic [3:0]      col_meta;
    logic [3:0]      col_s;
    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic [DW-1:0]   deb_cnt;
    logic            deb_done;
    logic [1:0]      row_idx;
    logic [1:0]      row_next;
    logic [1:0]      col_idx;
    logic [1:0]      low_col;
    logic            col_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_meta <= '1;
            col_s    <= '1;
        end else begin
            col_meta <= col_in;
            col_s    <= col_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == TW'(CLK_DIV - 1));

    always_comb begin
        low_col = 2'd3;
        if (!col_s[0]) begin
            low_col = 2'd0;
        end else if (!col_s[1]) begin
            low_col = 2'd1;
        end else if (!col_s[2]) begin
            low_col = 2'd2;
        end
    end

    assign col_hit  = ~col_s[col_idx];
    assign row_next = row_idx + 2'd1;
    // The counter stops one short: the tick that would make it reach the
    // threshold is the one that changes state, so it never holds the threshold.
    assign deb_done = (deb_cnt == DW'(DEBOUNCE_TICKS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= SCAN;
            row_idx       <= '0;
            row_out       <= 4'b1110;
            col_idx       <= '0;
            deb_cnt       <= '0;
            key_code      <= '0;
            enable_filter <= 1'b0;
        end else if (tick) begin
            case (state)
                SCAN: begin
                    if (col_s == 4'hF) begin
                        row_idx <= row_next;
                        row_out <= ~(4'b0001 << row_next);
                    end else begin
                        col_idx <= low_col;
                        deb_cnt <= '0;
                        state   <= DEB_PRESS;
                    end
                end
                DEB_PRESS: begin
                    if (!col_hit) begin
                        state <= SCAN;
                    end else if (deb_done) begin
                        deb_cnt       <= '0;
                        key_code      <= {row_idx, col_idx};
                        enable_filter <= 1'b1;
                        state         <= PRESSED;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!col_hit) begin
                        deb_cnt <= '0;
                        state   <= DEB_REL;
                    end
                end
                DEB_REL: begin
                    if (col_hit) begin
                        state <= PRESSED;
                    end else if (deb_done) begin
                        deb_cnt       <= '0;
                        enable_filter <= 1'b0;
                        row_idx       <= row_next;
                        row_out       <= ~(4'b0001 << row_next);
                        state         <= SCAN;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keyb_scan_debounce.sv
// Directed bench for keyb_scan_debounce: a 4x4 keypad model drives col_in from row_out.
module tb_keyb_scan_debounce;

    logic        clk;
    logic        reset;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [3:0]  key_code;
    logic        enable_filter;
    logic [15:0] pressed;
    int          cyc;
    int          n_cmp;
    int          n_err;

    keyb_scan_debounce #(
        .CLK_DIV        (4),
        .DEBOUNCE_TICKS (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .col_in        (col_in),
        .row_out       (row_out),
        .key_code      (key_code),
        .enable_filter (enable_filter)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Key r*4+c pulls column c low while row r is strobed.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic at(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_reset(input logic [15:0] keys);
        @(negedge clk);
        reset   = 1'b0;
        pressed = keys;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset   = 1'b0;
        pressed = '0;
        #12;
        check("rst_row", row_out, 4'b1110);
        check("rst_key", key_code, 4'h0);
        check("rst_enf", enable_filter, 1'b0);

        // Idle scan; first tick lands on the 4th edge after release
        do_reset(16'h0000);
        at(3);  check("idle_row3", row_out, 4'b1110);
        at(4);  check("idle_row4", row_out, 4'b1101);
        at(8);  check("idle_row8", row_out, 4'b1011);
        at(12); check("idle_row12", row_out, 4'b0111);
        at(16); check("idle_row16", row_out, 4'b1110);
        at(40); check("idle_row40", row_out, 4'b1011);
        check("idle_enf", enable_filter, 1'b0);

        // Clean press of row 1 col 2: detected at tick 8, accepted at edge 20
        do_reset(16'h0040);
        at(19); check("press_enf19", enable_filter, 1'b0);
        at(20); check("press_enf20", enable_filter, 1'b1);
        check("press_key", key_code, 4'd6);
        check("press_row", row_out, 4'b1101);
        at(38); check("press_hold_row", row_out, 4'b1101);

        // Release bounce: high at tick 44, low at 48, final release at 52
        for (int c = 40; c <= 63; c++) begin
            at(c);
            if (c == 40) pressed = 16'h0000;
            if (c == 44) pressed = 16'h0040;
            if (c == 48) pressed = 16'h0000;
            check("rel_enf_hold", enable_filter, 1'b1);
        end
        at(64);
        check("rel_enf_fall", enable_filter, 1'b0);
        check("rel_row", row_out, 4'b1011);
        check("rel_key_kept", key_code, 4'd6);
        at(68); check("rel_rescan", row_out, 4'b0111);

        // Press bounce on row 0 col 0: detected at tick 4, gone by tick 8
        do_reset(16'h0001);
        at(4); pressed = 16'h0000;
        for (int c = 4; c <= 24; c++) begin
            at(c);
            check("bnc_enf", enable_filter, 1'b0);
        end
        check("bnc_key", key_code, 4'd0);
        do_reset(16'h0001);
        at(4); pressed = 16'h0000;
        at(8);  check("bnc_row8", row_out, 4'b1110);
        at(11); check("bnc_row11", row_out, 4'b1110);
        at(12); check("bnc_row12", row_out, 4'b1101);
        at(16); check("bnc_row16", row_out, 4'b1011);

        // Row 3 with cols 1 and 3 low: lowest column wins
        do_reset(16'hA000);
        at(27); check("sim_enf27", enable_filter, 1'b0);
        at(28); check("sim_enf28", enable_filter, 1'b1);
        check("sim_key", key_code, 4'd13);
        check("sim_row", row_out, 4'b0111);

        // Asynchronous reset while PRESSED, sampled before the next clk edge
        at(30);
        #1 reset = 1'b0;
        #1;
        check("arst_enf", enable_filter, 1'b0);
        check("arst_key", key_code, 4'd0);
        check("arst_row", row_out, 4'b1110);
        pressed = '0;
        @(negedge clk);
        reset = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
